// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage. Accepts ALU results, runs load/store/push/pop
// through a req/ack memory port, and emits one writeback record per retired op.
module mem_wb_stage #(
  parameter int DATA_W      = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exe_mem,
  input  logic [9:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [3:0]        dest_reg,
  output logic              mem_blocked,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  // Counter is wide enough to reach ACK_TIMEOUT; a 1-bit dummy when timeouts are disabled.
  localparam int              CNT_W      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]  TIMEOUT_V  = (CNT_W + 1)'(ACK_TIMEOUT);
  localparam bit              TIMEOUT_EN = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_load_reg;
  logic [3:0]         dest_latched_reg;
  logic [CNT_W:0]     cnt_next;
  logic               timeout_hit;
  logic               op_is_load;
  logic               op_is_store;

  // Load class: plain load plus the pop range.
  function automatic logic is_load_op(input logic [9:0] op);
    return (op == 10'h040) || ((op >= 10'h058) && (op <= 10'h05F));
  endfunction

  // Store class: plain store plus the push range.
  function automatic logic is_store_op(input logic [9:0] op);
    return (op == 10'h048) || ((op >= 10'h050) && (op <= 10'h057));
  endfunction

  assign op_is_load  = is_load_op(opcode);
  assign op_is_store = is_store_op(opcode);

  // Count of REQ cycles spent without ack, including the current one.
  assign cnt_next    = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
  assign timeout_hit = TIMEOUT_EN && (cnt_next == TIMEOUT_V);

  // Stall is a pure decode of the state register, so no path from exe_mem reaches it.
  assign mem_blocked = (state_reg != S_IDLE);

  // FSM with all outputs registered; wb_valid/wb_en default low so they pulse one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      is_load_reg      <= 1'b0;
      dest_latched_reg <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      wb_valid         <= 1'b0;
      wb_en            <= 1'b0;
      wb_reg           <= '0;
      wb_data          <= '0;
      mem_err          <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (exe_mem) begin
            if (op_is_load || op_is_store) begin
              state_reg        <= S_REQ;
              cnt_reg          <= '0;
              is_load_reg      <= op_is_load;
              dest_latched_reg <= dest_reg;
              mem_req          <= 1'b1;
              mem_we           <= op_is_store;
              mem_addr         <= result;
              mem_wdata        <= op_is_store ? store_data : '0;
            end else begin
              // Pass-through op retires on the next cycle.
              wb_valid <= 1'b1;
              wb_en    <= 1'b1;
              wb_reg   <= dest_reg;
              wb_data  <= result;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            // Ack beats a coincident timeout; the writeback record is presented during RESP.
            state_reg <= S_RESP;
            mem_req   <= 1'b0;
            wb_valid  <= 1'b1;
            wb_en     <= is_load_reg;
            wb_reg    <= dest_latched_reg;
            wb_data   <= is_load_reg ? mem_rdata : '0;
          end else if (timeout_hit) begin
            state_reg <= S_RESP;
            mem_req   <= 1'b0;
            mem_err   <= 1'b1;
            wb_valid  <= 1'b1;
            wb_en     <= 1'b0;
            wb_reg    <= dest_latched_reg;
            wb_data   <= '0;
          end else begin
            cnt_reg <= cnt_next[CNT_W-1:0];
          end
        end
        S_RESP: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus random ops, scoreboard-checked.
module tb_mem_wb_stage;

  localparam int DW = 64;
  localparam int TO = 4;

  logic          clk;
  logic          reset_n;
  logic          exe_mem;
  logic [9:0]    opcode;
  logic [DW-1:0] result;
  logic [DW-1:0] store_data;
  logic [3:0]    dest_reg;
  logic          mem_blocked;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic          wb_en;
  logic [3:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic          mem_err;

  mem_wb_stage #(.DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .opcode(opcode),
    .result(result), .store_data(store_data), .dest_reg(dest_reg),
    .mem_blocked(mem_blocked), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            en;
    logic [3:0]    rg;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  typedef struct {
    logic [DW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
    int            ack_at;   // REQ cycle (1-based) in which ack is given; 0 = never
  } plan_t;

  exp_t          exp_q[$];
  plan_t         plan_q[$];
  logic [DW-1:0] model_mem[logic [DW-1:0]];
  logic [DW-1:0] resp_mem[logic [DW-1:0]];
  bit            err_sticky;
  int            checks;
  int            errors;

  function automatic logic [DW-1:0] dflt(input logic [DW-1:0] a);
    return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  function automatic bit m_is_load(input logic [9:0] op);
    return (op == 10'h040) || (op >= 10'h058 && op <= 10'h05F);
  endfunction

  function automatic bit m_is_store(input logic [9:0] op);
    return (op == 10'h048) || (op >= 10'h050 && op <= 10'h057);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: acts as the memory, and checks request shape and REQ duration.
  initial begin : responder
    plan_t cur;
    bit    active;
    int    req_cycles;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    active     = 0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active     = 0;
        req_cycles = 0;
        mem_ack    = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: addr %h", mem_addr);
            cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata; cur.ack_at = 1;
          end else begin
            cur = plan_q.pop_front();
          end
          active     = 1;
          req_cycles = 0;
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_we", {63'b0, mem_we}, {63'b0, cur.we});
          chk("mem_wdata", mem_wdata, cur.wdata);
        end
        req_cycles++;
        if (cur.ack_at != 0 && req_cycles == cur.ack_at) begin
          chk("mem_addr_stable", mem_addr, cur.addr);
          mem_ack = 1'b1;
          if (cur.we) begin
            resp_mem[cur.addr] = cur.wdata;
            mem_rdata = {$urandom, $urandom};
          end else begin
            mem_rdata = resp_mem.exists(cur.addr) ? resp_mem[cur.addr] : dflt(cur.addr);
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        mem_ack = 1'b0;
        if (active) begin
          chk("req_cycles", 64'(req_cycles), 64'((cur.ack_at != 0) ? cur.ack_at : TO));
          active = 0;
        end
      end
    end
  end

  // Monitor: every writeback pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: reg %0d data %h", wb_reg, wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_en", {63'b0, wb_en}, {63'b0, e.en});
          chk("wb_reg", {60'b0, wb_reg}, {60'b0, e.rg});
          chk("wb_data", wb_data, e.data);
          chk("mem_err", {63'b0, mem_err}, {63'b0, e.err});
          $display("wb: en=%0b reg=%0d data=%h err=%0b", wb_en, wb_reg, wb_data, mem_err);
        end
      end
    end
  end

  // Issue one op: record expectations from the reference model, hold until accepted.
  task automatic issue(input logic [9:0] op, input logic [DW-1:0] res, input logic [DW-1:0] sd,
                       input logic [3:0] dr, input int ack_at);
    exp_t  e;
    plan_t p;
    bit    blk;
    bit    ok;
    e.rg = dr; e.en = 0; e.data = '0;
    if (m_is_load(op) || m_is_store(op)) begin
      p.addr = res; p.we = m_is_store(op); p.wdata = p.we ? sd : '0; p.ack_at = ack_at;
      plan_q.push_back(p);
      if (ack_at == 0) begin
        err_sticky = 1;
      end else if (p.we) begin
        model_mem[res] = sd;
      end else begin
        e.en   = 1;
        e.data = model_mem.exists(res) ? model_mem[res] : dflt(res);
      end
    end else begin
      e.en = 1; e.data = res;
    end
    e.err = err_sticky;
    exp_q.push_back(e);
    $display("issue: op=%h res=%h sd=%h dest=%0d ack_at=%0d", op, res, sd, dr, ack_at);
    exe_mem = 1'b1; opcode = op; result = res; store_data = sd; dest_reg = dr;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      blk = mem_blocked;
      @(posedge clk);
      if (!blk) begin ok = 1; break; end
    end
    #1;
    exe_mem = 1'b0;
    result  = {$urandom, $urandom};
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: op %h never accepted", op);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && plan_q.size() == 0) begin done = 1; break; end
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain: %0d wb and %0d req outstanding", exp_q.size(), plan_q.size());
    end
  endtask

  initial begin : main
    int            nblk;
    int            k;
    logic [9:0]    op;
    logic [DW-1:0] addr;
    reset_n = 1'b0; exe_mem = 1'b0; opcode = '0; result = '0; store_data = '0; dest_reg = '0;
    err_sticky = 0; checks = 0; errors = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_mem_blocked", {63'b0, mem_blocked}, 64'd0);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rst_wb_en", {63'b0, wb_en}, 64'd0);
    chk("rst_mem_err", {63'b0, mem_err}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // PASS with one-cycle latency and no stall.
    issue(10'h001, 64'h5, 64'h0, 4'd3, 0);
    @(negedge clk);
    chk("pass_latency_wb_valid", {63'b0, wb_valid}, 64'd1);
    chk("pass_mem_blocked", {63'b0, mem_blocked}, 64'd0);
    @(posedge clk); #1;

    // LOAD acked in the 3rd REQ cycle; stall lasts REQ(3)+RESP(1).
    model_mem[64'h1000] = 64'hDEAD;
    resp_mem[64'h1000]  = 64'hDEAD;
    issue(10'h040, 64'h1000, 64'h0, 4'd7, 3);
    nblk = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_blocked) break;
      nblk++;
    end
    chk("load_blocked_cycles", 64'(nblk), 64'd4);
    @(posedge clk); #1;

    // PUSH acked in the first REQ cycle.
    issue(10'h050, 64'h7FF8, 64'h42, 4'd2, 1);
    drain();

    // Timeout: no ack, mem_err becomes sticky.
    issue(10'h05C, 64'h2000, 64'h0, 4'd9, 0);
    drain();
    chk("mem_err_sticky", {63'b0, mem_err}, 64'd1);

    // Stall: PASS held on exe_mem during a LOAD retires once, after it.
    issue(10'h058, 64'h1000, 64'h0, 4'd4, 2);
    issue(10'h123, 64'hCAFE, 64'h0, 4'd5, 0);
    drain();

    // Randomized mix, including ack in the timeout cycle and back-to-back ops.
    for (int n = 0; n < 80; n++) begin
      k    = int'($urandom_range(0, 9));
      addr = 64'h1000 + {58'b0, 3'($urandom_range(0, 7)), 3'b0};
      if (k < 4) begin
        do op = 10'($urandom); while (m_is_load(op) || m_is_store(op));
        issue(op, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 0);
      end else if (k < 7) begin
        op = (($urandom & 1) != 0) ? 10'h040 : 10'h058 + 10'($urandom_range(0, 7));
        issue(op, addr, {$urandom, $urandom}, 4'($urandom),
              (($urandom_range(0, 7)) == 0) ? 0 : int'($urandom_range(1, TO)));
      end else begin
        op = (($urandom & 1) != 0) ? 10'h048 : 10'h050 + 10'($urandom_range(0, 7));
        issue(op, addr, {$urandom, $urandom}, 4'($urandom),
              (($urandom_range(0, 7)) == 0) ? 0 : int'($urandom_range(1, TO)));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // Reset in the middle of REQ drops the op and clears everything at once.
    issue(10'h040, 64'h3000, 64'h0, 4'd6, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("arst_mem_blocked", {63'b0, mem_blocked}, 64'd0);
    chk("arst_mem_err", {63'b0, mem_err}, 64'd0);
    chk("arst_wb_valid", {63'b0, wb_valid}, 64'd0);
    exp_q.delete();
    plan_q.delete();
    err_sticky = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(10'h002, 64'h77, 64'h0, 4'd1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
